// File: rtl/spi_reg_slave.sv
// SPI target bridging serial register commands (0x10 read, 0x2F write) onto a 32-bit register bus.
// All SPI pins are oversampled in the mclk domain.
//
// state | meaning
// IDLE  | waiting for ssn to fall
// CMD   | shifting in the command byte
// ADDR  | shifting in the 32-bit address
// WDATA | shifting in the 32-bit write data
// DUMMY | turnaround byte; the read is in flight on the bus
// RDATA | shifting the read data out on sdo
// SKIP  | ignoring sclk until ssn returns high
module spi_reg_slave #(
    parameter int          SYNC_STG = 2,
    parameter logic [31:0] TMO_DATA = 32'hDEAD_BEEF
) (
    input  logic        mclk_i,
    input  logic        reset_i,
    input  logic        sclk_i,
    input  logic        ssn_i,
    input  logic        sdi_i,
    output logic        sdo_o,
    output logic        sdo_en_o,
    output logic        reg_cs_o,
    output logic        reg_wr_o,
    output logic [31:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic [3:0]  reg_be_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_ack_i,
    output logic        cmd_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_DUMMY,
        ST_RDATA,
        ST_SKIP
    } state_t;

    localparam logic [7:0] CMD_RD       = 8'h10;
    localparam logic [7:0] CMD_WR       = 8'h2F;
    localparam logic [6:0] CNT_CMD_END  = 7'd7;
    localparam logic [6:0] CNT_ADDR_END = 7'd39;
    localparam logic [6:0] CNT_WD_END   = 7'd71;
    localparam logic [6:0] CNT_RDUM_END = 7'd47;
    localparam logic [6:0] CNT_WDUM_END = 7'd79;
    localparam logic [6:0] CNT_RD_END   = 7'd79;

    logic [SYNC_STG-1:0] sclk_sync_q;
    logic [SYNC_STG-1:0] ssn_sync_q;
    logic [SYNC_STG-1:0] sdi_sync_q;
    logic                sclk_prev_q;
    logic                ssn_prev_q;

    logic        sclk_s;
    logic        ssn_s;
    logic        sdi_s;
    logic        rise;
    logic        fall;
    logic        ssn_fall;

    state_t      state_q;
    logic [6:0]  bit_cnt_q;
    logic [30:0] sin_q;
    logic [31:0] sin_d;
    logic        is_wr_q;
    logic [31:0] addr_q;
    logic [30:0] sout_q;
    logic        ld_done_q;
    logic        sdo_q;
    logic        sdo_en_q;
    logic [31:0] rdata_q;
    logic        rd_ok_q;
    logic        cmd_err_q;

    logic        reg_cs_q;
    logic        reg_wr_q;
    logic [31:0] reg_addr_q;
    logic [31:0] reg_wdata_q;
    logic        cs_live_q;
    logic        pend_q;
    logic        stg_wr_q;
    logic [31:0] stg_addr_q;
    logic [31:0] stg_wdata_q;

    logic        abort;
    logic        req_fire;
    logic        req_wr;
    logic [31:0] req_addr;
    logic        first_fall;
    logic        timeout;
    logic        drop_pend;

    always_ff @(posedge mclk_i) begin
        if (reset_i) begin
            sclk_sync_q <= '0;
            ssn_sync_q  <= '1;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            ssn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], sclk_i};
            ssn_sync_q  <= {ssn_sync_q[SYNC_STG-2:0], ssn_i};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STG-2:0], sdi_i};
            sclk_prev_q <= sclk_s;
            ssn_prev_q  <= ssn_s;
        end
    end

    assign sclk_s   = sclk_sync_q[SYNC_STG-1];
    assign ssn_s    = ssn_sync_q[SYNC_STG-1];
    assign sdi_s    = sdi_sync_q[SYNC_STG-1];
    assign rise     = sclk_s & ~sclk_prev_q;
    assign fall     = ~sclk_s & sclk_prev_q;
    assign ssn_fall = ssn_prev_q & ~ssn_s;

    always_comb begin
        sin_d    = {sin_q, sdi_s};
        abort    = ssn_s && (state_q != ST_IDLE);
        req_fire = 1'b0;
        req_wr   = 1'b0;
        if (!abort && rise) begin
            if (state_q == ST_ADDR && bit_cnt_q == CNT_ADDR_END && !is_wr_q) begin
                req_fire = 1'b1;
            end
            if (state_q == ST_WDATA && bit_cnt_q == CNT_WD_END) begin
                req_fire = 1'b1;
                req_wr   = 1'b1;
            end
        end
        req_addr   = (state_q == ST_ADDR) ? sin_d : addr_q;
        first_fall = (state_q == ST_RDATA) && fall && !ld_done_q && !abort;
        timeout    = first_fall && !rd_ok_q;
        // a queued read is useless once its frame is gone or has timed out
        drop_pend  = pend_q && !stg_wr_q && (abort || timeout);
    end

    always_ff @(posedge mclk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sin_q       <= '0;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            sout_q      <= '0;
            ld_done_q   <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_en_q    <= 1'b0;
            rdata_q     <= '0;
            rd_ok_q     <= 1'b0;
            cmd_err_q   <= 1'b0;
            reg_cs_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            cs_live_q   <= 1'b0;
            pend_q      <= 1'b0;
            stg_wr_q    <= 1'b0;
            stg_addr_q  <= '0;
            stg_wdata_q <= '0;
        end else begin
            cmd_err_q <= 1'b0;

            if (reg_cs_q) begin
                if (reg_ack_i) begin
                    reg_cs_q  <= 1'b0;
                    cs_live_q <= 1'b0;
                    if (cs_live_q) begin
                        rdata_q <= reg_rdata_i;
                        rd_ok_q <= 1'b1;
                    end
                end
            end else if (pend_q && !drop_pend) begin
                reg_cs_q    <= 1'b1;
                reg_wr_q    <= stg_wr_q;
                reg_addr_q  <= stg_addr_q;
                reg_wdata_q <= stg_wdata_q;
                cs_live_q   <= !stg_wr_q;
                pend_q      <= 1'b0;
            end

            if (req_fire) begin
                stg_wr_q    <= req_wr;
                stg_addr_q  <= req_addr;
                stg_wdata_q <= sin_d;
                if (!reg_cs_q && !pend_q) begin
                    reg_cs_q    <= 1'b1;
                    reg_wr_q    <= req_wr;
                    reg_addr_q  <= req_addr;
                    reg_wdata_q <= sin_d;
                    cs_live_q   <= !req_wr;
                end else begin
                    pend_q <= 1'b1;
                end
            end

            if (drop_pend) begin
                pend_q <= 1'b0;
            end

            if (abort) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                sin_q     <= '0;
                sout_q    <= '0;
                sdo_q     <= 1'b0;
                sdo_en_q  <= 1'b0;
                cs_live_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        bit_cnt_q <= '0;
                        if (ssn_fall) begin
                            state_q <= ST_CMD;
                            rd_ok_q <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (rise) begin
                            sin_q     <= sin_d[30:0];
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (bit_cnt_q == CNT_CMD_END) begin
                                if (sin_d[7:0] == CMD_RD) begin
                                    is_wr_q <= 1'b0;
                                    state_q <= ST_ADDR;
                                end else if (sin_d[7:0] == CMD_WR) begin
                                    is_wr_q <= 1'b1;
                                    state_q <= ST_ADDR;
                                end else begin
                                    cmd_err_q <= 1'b1;
                                    state_q   <= ST_SKIP;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise) begin
                            sin_q     <= sin_d[30:0];
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (bit_cnt_q == CNT_ADDR_END) begin
                                addr_q  <= sin_d;
                                state_q <= is_wr_q ? ST_WDATA : ST_DUMMY;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (rise) begin
                            sin_q     <= sin_d[30:0];
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (bit_cnt_q == CNT_WD_END) begin
                                state_q <= ST_DUMMY;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (rise) begin
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (is_wr_q && bit_cnt_q == CNT_WDUM_END) begin
                                state_q <= ST_SKIP;
                            end else if (!is_wr_q && bit_cnt_q == CNT_RDUM_END) begin
                                state_q   <= ST_RDATA;
                                sdo_en_q  <= 1'b1;
                                ld_done_q <= 1'b0;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (rise) begin
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (bit_cnt_q == CNT_RD_END) begin
                                state_q  <= ST_SKIP;
                                sdo_en_q <= 1'b0;
                                sdo_q    <= 1'b0;
                            end
                        end else if (first_fall) begin
                            ld_done_q <= 1'b1;
                            if (rd_ok_q) begin
                                sdo_q  <= rdata_q[31];
                                sout_q <= rdata_q[30:0];
                            end else begin
                                // missed deadline: the late ack, when it comes, is discarded
                                sdo_q     <= TMO_DATA[31];
                                sout_q    <= TMO_DATA[30:0];
                                cmd_err_q <= 1'b1;
                                cs_live_q <= 1'b0;
                            end
                        end else if (fall) begin
                            sdo_q  <= sout_q[30];
                            sout_q <= {sout_q[29:0], 1'b0};
                        end
                    end
                    ST_SKIP: begin
                        bit_cnt_q <= bit_cnt_q;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sdo_o       = sdo_q;
    assign sdo_en_o    = sdo_en_q;
    assign reg_cs_o    = reg_cs_q;
    assign reg_wr_o    = reg_wr_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_be_o    = 4'hF;
    assign cmd_err_o   = cmd_err_q;

endmodule
